mem_access_unit: RTL
====================

# mem_access_unit

Load/store unit between the CPU execute stage and the data port of the byte-addressable dual-port RAM. It converts RV32I loads and stores of every width into the word-only accesses the RAM supports. Loads are aligned, lane-extracted and sign- or zero-extended. Byte and halfword stores run as read-modify-write sequences. Misaligned and illegal requests are rejected without touching memory.

## Interface

- ADDR_WIDTH, default 32: width of request and memory addresses.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU presents an access
- req_ready  out  1  unit accepts; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid; access rejected
- mem_en  out  1  RAM data-port enable
- mem_wr  out  1  RAM write strobe
- mem_addr  out  ADDR_WIDTH  word-aligned address {req_addr[AW-1:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  RAM read word, valid one cycle after mem_en

## Operation

- Handshake: accept on the rising edge where req_valid && req_ready. On accept, latch we, funct3, addr and wdata. Request inputs are ignored at all other times.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE → RESP when the request is rejected.
  - IDLE → WRITE for an aligned SW.
  - IDLE → READ for all loads, SB and SH.
  - READ → WAIT.
  - WAIT → RESP for a load.
  - WAIT → WRITE for SB or SH.
  - WRITE → RESP.
  - RESP → IDLE.
- A request is rejected when:
  - H/HU has addr[0]=1;
  - W has addr[1:0]≠0;
  - funct3 ∈ {011,110,111};
  - or it is a store with funct3 100 or 101.
- Memory outputs are a Moore decode of state:
  - READ: mem_en=1, mem_wr=0.
  - WRITE: mem_en=1, mem_wr=1.
  - All other states: mem_en=0, mem_wr=0, mem_wdata=0.
  - mem_addr holds the latched aligned address.
- Load extraction in WAIT, registered into resp_rdata:
  - Byte lane = addr[1:0], byte = mem_rdata[8*lane+:8].
  - Half = mem_rdata[16*addr[1]+:16].
  - B and H sign-extend. BU and HU zero-extend. W passes the word through.
- Store merge in WAIT, registered into the write buffer:
  - SB replaces byte lane addr[1:0] of mem_rdata with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - SW writes wdata directly and skips READ/WAIT.
- RESP: resp_valid=1 for exactly one cycle. resp_misaligned is 1 only for rejected requests, and their resp_rdata=0.
- resp_rdata and resp_misaligned hold their values until the next RESP.
- A rejected request never asserts mem_en, so memory is unchanged.

## Timing

- Cycle numbers count from the accept edge E0.
  - Load: READ in cycle 1, WAIT in cycle 2, resp_valid in cycle 3.
  - SW: WRITE in cycle 1, resp_valid in cycle 2.
  - SB/SH: READ 1, WAIT 2, WRITE 3, resp_valid 4.
  - Rejected: resp_valid in cycle 1.
- req_ready=0 from cycle 1 through RESP. The next accept is possible in the first IDLE cycle after RESP.
- Throughput is one access per 2–5 cycles. Requests are never dropped; a held req_valid is accepted when IDLE is reached.
- The RAM returns the pre-write value on a same-edge read/write. This never occurs here because READ and WRITE are separate cycles.
- Reset (asynchronous, any state): state goes to IDLE and all registers clear.
  - Output values while reset is asserted: req_ready=1; resp_valid, resp_rdata, resp_misaligned, mem_en, mem_wr, mem_addr and mem_wdata all 0.
  - Reset during READ or WAIT: no write occurs.
  - Reset asserted before the WRITE edge: mem_en drops immediately and the write is suppressed.
  - No resp_valid is issued for an aborted request.

## Test plan

All scenarios start with word 0x100 = 0x80FF7F01.

- Byte loads:
  - LB 0x102 → 0xFFFFFFFF.
  - LBU 0x102 → 0x000000FF.
  - LB 0x101 → 0x0000007F.
  - Each returns resp_valid exactly 3 cycles after accept, with mem_en high for one cycle only.
- Halfword and word loads:
  - LH 0x102 → 0xFFFF80FF.
  - LHU 0x102 → 0x000080FF.
  - LW 0x100 → 0x80FF7F01.
  - resp_misaligned=0 in all cases.
- Sub-word stores:
  - SB 0x101 with wdata 0x12345678 → word becomes 0x80FF7801.
  - SH 0x102 with wdata 0xDEADBEEF, issued next → word becomes 0xBEEF7801.
  - Each shows mem_en in cycles 1 and 3, mem_wr only in cycle 3, and resp_valid in cycle 4.
- Word store: SW 0x104 with wdata 0xCAFEF00D → a single write in cycle 1, resp_valid in cycle 2, and LW 0x104 then returns 0xCAFEF00D.
- Rejections: LW 0x102, SH 0x101, funct3=011 and SB-with-funct3=100 (a store using funct3 100) each give resp_valid with resp_misaligned=1 in cycle 1 and resp_rdata=0. mem_en never rises and all words are unchanged.
- Reset and back-to-back requests:
  - Assert rst in WAIT of SB 0x100 → mem_en stays 0, the word is unchanged, req_ready=1, and no resp_valid is issued.
  - With req_valid held for two loads, the second is accepted in the cycle after RESP.

Source files
------------

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: turns B/H/W loads and stores into word-only RAM accesses.
// Sub-word stores run as read-modify-write; misaligned or illegal requests are rejected.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wbuf_q, wbuf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  mis_q, mis_d;

    logic                  reject;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_ext;
    logic [31:0]           st_merge;

    // Rejection is decided on the live request, before anything is latched.
    always_comb begin
        reject = 1'b0;
        case (req_funct3)
            F3_B:    reject = 1'b0;
            F3_BU:   reject = req_we;
            F3_H:    reject = req_addr[0];
            F3_HU:   reject = req_we | req_addr[0];
            F3_W:    reject = (req_addr[1:0] != 2'b00);
            default: reject = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        ld_ext = mem_rdata;
        case (funct3_q)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_ext = {24'h0, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // wbuf_q still holds rs2 here; only its low byte/half is merged in.
    always_comb begin
        st_merge = mem_rdata;
        if (funct3_q == F3_H) begin
            if (addr_q[1]) begin
                st_merge[31:16] = wbuf_q[15:0];
            end else begin
                st_merge[15:0] = wbuf_q[15:0];
            end
        end else begin
            case (addr_q[1:0])
                2'd0:    st_merge[7:0]   = wbuf_q[7:0];
                2'd1:    st_merge[15:8]  = wbuf_q[7:0];
                2'd2:    st_merge[23:16] = wbuf_q[7:0];
                default: st_merge[31:24] = wbuf_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wbuf_d   = wbuf_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wbuf_d   = req_wdata;
                    if (reject) begin
                        rdata_d = 32'h0;
                        mis_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (req_we && req_funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (we_q) begin
                    wbuf_d  = st_merge;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = ld_ext;
                    mis_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                rdata_d = 32'h0;
                mis_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wbuf_q   <= 32'h0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign resp_valid      = (state_q == S_RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign mem_en          = (state_q == S_READ) || (state_q == S_WRITE);
    assign mem_wr          = (state_q == S_WRITE);
    assign mem_addr        = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata       = (state_q == S_WRITE) ? wbuf_q : 32'h0;

endmodule
